// File: rtl/bee_motion_ctrl.sv
// bee_motion_ctrl: once-per-frame motion sequencer for the Bee sprite.
// Fires a one-cycle frame_tick on the first vertical-blank line. Every
// FRAMES_PER_STEP enabled ticks it steps the sprite origin: the sprite runs
// horizontally, drops and reverses at the edges, and freezes at the bottom.
// Optional feature macro: BEE_MOTION_PAUSE_EN (adds a pause toggle input).
module bee_motion_ctrl #(
  parameter int H_RES           = 640,
  parameter int V_TICK_LINE     = 480,
  parameter int SPRITE_W        = 34,
  parameter int X_INIT          = 303,
  parameter int Y_INIT          = 40,
  parameter int STEP_X          = 1,
  parameter int DROP_Y          = 8,
  parameter int Y_MAX           = 400,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic       clk_pix,
  input  logic       rst_pix_n,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       enable,
`ifdef BEE_MOTION_PAUSE_EN
  input  logic       pause,
`endif
  output logic [9:0] bee_x,
  output logic [9:0] bee_y,
  output logic       dir,
  output logic       frame_tick,
  output logic       at_bottom
);

  // 11-bit constants so every compare/sum has headroom and cannot wrap
  localparam logic [10:0] X_MAX11   = 11'(H_RES - SPRITE_W);
  localparam logic [10:0] STEP_X11  = 11'(STEP_X);
  localparam logic [10:0] DROP_Y11  = 11'(DROP_Y);
  localparam logic [10:0] Y_MAX11   = 11'(Y_MAX);
  localparam logic [9:0]  TICK_LINE = 10'(V_TICK_LINE);
  localparam logic [9:0]  X_RST     = 10'(X_INIT);
  localparam logic [9:0]  Y_RST     = 10'(Y_INIT);
  localparam logic [7:0]  CNT_LAST  = 8'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {RUN, DROP, BOTTOM} state_t;

  state_t      state_q, state_d;
  logic [9:0]  bee_x_q, bee_x_d;
  logic [9:0]  bee_y_q, bee_y_d;
  logic        dir_q, dir_d;
  logic        frame_tick_q, frame_tick_d;
  logic        at_bottom_q, at_bottom_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        paused;

  logic        tick;
  logic        step;
  logic [10:0] x11, y11, x_fwd, y_drop;

`ifdef BEE_MOTION_PAUSE_EN
  logic pause_q, pause_d;
  logic pause_dly_q, pause_dly_d;
  logic paused_q, paused_d;

  // Register pause, then toggle the paused flag on its registered rising edge
  always_comb begin
    pause_d     = pause;
    pause_dly_d = pause_q;
    paused_d    = paused_q;
    if (pause_q && !pause_dly_q) paused_d = ~paused_q;
  end

  // Pause-path state
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      pause_q     <= 1'b0;
      pause_dly_q <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      pause_q     <= pause_d;
      pause_dly_q <= pause_dly_d;
      paused_q    <= paused_d;
    end
  end

  assign paused = paused_q;
`else
  assign paused = 1'b0;
`endif

  // Frame tick detect and step prescaler; counter only moves when stepping is allowed
  always_comb begin
    tick         = (sx == 10'd0) && (sy == TICK_LINE);
    frame_tick_d = tick;
    cnt_d        = cnt_q;
    step         = 1'b0;
    if (tick && enable && !paused) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = 8'd0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Motion FSM: next state and next sprite origin, evaluated only on step edges
  always_comb begin
    state_d = state_q;
    bee_x_d = bee_x_q;
    bee_y_d = bee_y_q;
    dir_d   = dir_q;
    x11     = {1'b0, bee_x_q};
    y11     = {1'b0, bee_y_q};
    x_fwd   = x11 + STEP_X11;
    y_drop  = y11 + DROP_Y11;
    unique case (state_q)
      RUN: if (step) begin
        if (dir_q) begin
          if (x_fwd > X_MAX11) state_d = DROP;
          else                 bee_x_d = x_fwd[9:0];
        end else begin
          if (x11 < STEP_X11)  state_d = DROP;
          else                 bee_x_d = 10'(x11 - STEP_X11);
        end
      end
      DROP: if (step) begin
        bee_y_d = y_drop[9:0];
        dir_d   = ~dir_q;
        state_d = (y_drop >= Y_MAX11) ? BOTTOM : RUN;
      end
      BOTTOM: ;
      default: state_d = RUN;
    endcase
    at_bottom_d = (state_d == BOTTOM);
  end

  // All state and outputs registered; synchronous active-low reset
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state_q      <= RUN;
      bee_x_q      <= X_RST;
      bee_y_q      <= Y_RST;
      dir_q        <= 1'b1;
      frame_tick_q <= 1'b0;
      at_bottom_q  <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      bee_x_q      <= bee_x_d;
      bee_y_q      <= bee_y_d;
      dir_q        <= dir_d;
      frame_tick_q <= frame_tick_d;
      at_bottom_q  <= at_bottom_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bee_x      = bee_x_q;
  assign bee_y      = bee_y_q;
  assign dir        = dir_q;
  assign frame_tick = frame_tick_q;
  assign at_bottom  = at_bottom_q;

endmodule

// File: tb/tb_bee_motion_ctrl.sv
// Directed bench for bee_motion_ctrl: three instances share the raster
// inputs -- default parameters, a right-edge start and a near-bottom start.
module tb_bee_motion_ctrl;

  logic       clk_pix = 1'b0;
  logic       rst_pix_n;
  logic [9:0] sx, sy;
  logic       enable;
`ifdef BEE_MOTION_PAUSE_EN
  logic       pause;
`endif

  logic [9:0] d_x, d_y, e_x, e_y, b_x, b_y;
  logic       d_dir, d_ft, d_bot, e_dir, e_ft, e_bot, b_dir, b_ft, b_bot;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_pix = ~clk_pix;

  bee_motion_ctrl u_def (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .enable(enable),
`ifdef BEE_MOTION_PAUSE_EN
    .pause(pause),
`endif
    .bee_x(d_x), .bee_y(d_y), .dir(d_dir), .frame_tick(d_ft), .at_bottom(d_bot));

  bee_motion_ctrl #(.X_INIT(605), .FRAMES_PER_STEP(1)) u_edge (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .enable(enable),
`ifdef BEE_MOTION_PAUSE_EN
    .pause(pause),
`endif
    .bee_x(e_x), .bee_y(e_y), .dir(e_dir), .frame_tick(e_ft), .at_bottom(e_bot));

  bee_motion_ctrl #(.X_INIT(606), .Y_INIT(392), .FRAMES_PER_STEP(1)) u_bot (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .enable(enable),
`ifdef BEE_MOTION_PAUSE_EN
    .pause(pause),
`endif
    .bee_x(b_x), .bee_y(b_y), .dir(b_dir), .frame_tick(b_ft), .at_bottom(b_bot));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present the tick position for one edge; outputs sampled 1 after that edge
  task automatic do_tick();
    @(negedge clk_pix); sx = 10'd0; sy = 10'd480;
    @(posedge clk_pix); #1;
  endtask

  // Present a non-tick position for one edge
  task automatic idle(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk_pix); sx = x; sy = y;
    @(posedge clk_pix); #1;
  endtask

  initial begin
    rst_pix_n = 1'b0; sx = 10'd5; sy = 10'd5; enable = 1'b1;
`ifdef BEE_MOTION_PAUSE_EN
    pause = 1'b0;
`endif
    // 1: reset
    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix); rst_pix_n = 1'b1;
    idle(10'd5, 10'd5);
    chk("rst_x", d_x, 303); chk("rst_y", d_y, 40); chk("rst_dir", d_dir, 1);
    chk("rst_bot", d_bot, 0); chk("rst_ft", d_ft, 0);
    chk("rst_edge_x", e_x, 605); chk("rst_bot_y", b_y, 392);

    // sx!=0 on the tick line must not tick
    idle(10'd1, 10'd480);
    chk("no_tick_sx1", d_ft, 0);

    // 2/3/4: ticks 1..4
    do_tick();
    chk("t1_ft", d_ft, 1); chk("t1_x", d_x, 303);
    chk("t1_edge_x", e_x, 606); chk("t1_bot_x", b_x, 606);
    idle(10'd7, 10'd12);
    chk("t1_ft_low", d_ft, 0);

    do_tick();
    chk("t2_ft", d_ft, 1); chk("t2_x", d_x, 304);
    chk("t2_edge_x", e_x, 606); chk("t2_edge_y", e_y, 40);
    chk("t2_bot_y", b_y, 400); chk("t2_bot_flag", b_bot, 1); chk("t2_bot_dir", b_dir, 0);
    idle(10'd7, 10'd12);
    chk("t2_ft_low", d_ft, 0);

    do_tick();
    chk("t3_x", d_x, 304);
    chk("t3_edge_y", e_y, 48); chk("t3_edge_dir", e_dir, 0); chk("t3_edge_x", e_x, 606);
    chk("t3_edge_bot", e_bot, 0);
    idle(10'd7, 10'd12);

    do_tick();
    chk("t4_x", d_x, 305); chk("t4_edge_x", e_x, 605);
    idle(10'd7, 10'd12);

    // 10 further ticks: bottom frozen, others keep moving
    for (int i = 0; i < 10; i++) begin
      do_tick();
      idle(10'd3, 10'd100);
    end
    chk("t14_x", d_x, 310); chk("t14_edge_x", e_x, 595);
    chk("frz_x", b_x, 606); chk("frz_y", b_y, 400); chk("frz_dir", b_dir, 0);
    chk("frz_bot", b_bot, 1);

    // 5: enable low -> no motion, ticks continue
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_tick();
      chk("dis_ft", d_ft, 1);
      idle(10'd3, 10'd100);
    end
    chk("dis_x", d_x, 310); chk("dis_edge_x", e_x, 595);
    enable = 1'b1;
    do_tick();
    chk("en1_x", d_x, 310); chk("en1_edge_x", e_x, 594);
    idle(10'd3, 10'd100);
    do_tick();
    chk("en2_x", d_x, 311); chk("en2_edge_x", e_x, 593);

    // mid-frame reset
    @(negedge clk_pix); sx = 10'd100; sy = 10'd200; rst_pix_n = 1'b0;
    @(posedge clk_pix); #1;
    chk("mr_x", d_x, 303); chk("mr_y", d_y, 40); chk("mr_dir", d_dir, 1);
    chk("mr_ft", d_ft, 0);
    chk("mr_edge_x", e_x, 605); chk("mr_edge_dir", e_dir, 1);
    chk("mr_bot_flag", b_bot, 0); chk("mr_bot_y", b_y, 392);
    @(negedge clk_pix); rst_pix_n = 1'b1;

`ifdef BEE_MOTION_PAUSE_EN
    // 6: pause toggles stepping
    @(negedge clk_pix); pause = 1'b1;
    @(negedge clk_pix); pause = 1'b0;
    repeat (3) idle(10'd3, 10'd100);
    for (int i = 0; i < 4; i++) begin
      do_tick();
      chk("pz_ft", d_ft, 1);
      idle(10'd3, 10'd100);
    end
    chk("pz_x", d_x, 303);
    @(negedge clk_pix); pause = 1'b1;
    @(negedge clk_pix); pause = 1'b0;
    repeat (3) idle(10'd3, 10'd100);
    do_tick(); idle(10'd3, 10'd100);
    do_tick();
    chk("unpz_x", d_x, 304);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
